// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine: context save/restore engine for the 32x32 MIPS register
// file. SAVE walks registers FIRST_REG..LAST_REG through the read port and
// streams them out; RESTORE takes a word stream and writes the same range
// through the write port.
//
// Handshake rule used on both streams: a word moves on a rising clock edge
// exactly when valid and ready are both high in the cycle before that edge.
// A producer never drops valid or changes data while valid=1 and ready=0;
// the only exceptions are abort and reset. ready may be driven freely and
// carries no obligation when valid is low.
module regfile_ctx_engine #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_read_addr,
  input  logic [31:0] rf_read_data,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        rf_write_en,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SAVE       = 2'd1,
    ST_SAVE_DRAIN = 2'd2,
    ST_RESTORE    = 2'd3
  } state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t      state;
  state_t      state_next;
  logic [4:0]  idx;
  logic [4:0]  idx_next;
  logic [31:0] out_data_next;
  logic        out_valid_next;
  logic        done_next;

  // Transfer strobes shared by the next-state, datapath and output logic.
  logic at_last;
  logic save_load;
  logic drain_fire;
  logic restore_fire;

  // Decode which transfer (if any) happens at the coming edge.
  always_comb begin
    at_last      = (idx == LAST_IDX);
    // The output register refills whenever it is empty or being emptied.
    save_load    = (state == ST_SAVE) && (!out_valid || out_ready);
    drain_fire   = (state == ST_SAVE_DRAIN) && out_valid && out_ready;
    // in_ready is 1 throughout RESTORE, so in_valid alone completes a beat.
    restore_fire = (state == ST_RESTORE) && in_valid;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort takes priority over any transfer completing.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = mode ? ST_RESTORE : ST_SAVE;
        end
      end
      ST_SAVE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (save_load && at_last) begin
          state_next = ST_SAVE_DRAIN;
        end
      end
      ST_SAVE_DRAIN: begin
        if (abort || drain_fire) begin
          state_next = ST_IDLE;
        end
      end
      ST_RESTORE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (restore_fire && at_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath next values: register index, output word register and done.
  // idx is parked at FIRST_REG whenever the engine returns to IDLE so the
  // idle read address matches the reset value. idx only advances when it
  // is below LAST_REG, so it can never wrap.
  always_comb begin
    idx_next       = idx;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    done_next      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_next = FIRST_IDX;
        end
      end
      ST_SAVE: begin
        if (abort) begin
          out_valid_next = 1'b0;
          idx_next       = FIRST_IDX;
        end else if (save_load) begin
          out_data_next  = rf_read_data;
          out_valid_next = 1'b1;
          if (!at_last) begin
            idx_next = idx + 5'd1;
          end
        end
      end
      ST_SAVE_DRAIN: begin
        if (abort) begin
          out_valid_next = 1'b0;
          idx_next       = FIRST_IDX;
        end else if (drain_fire) begin
          out_valid_next = 1'b0;
          done_next      = 1'b1;
          idx_next       = FIRST_IDX;
        end
      end
      ST_RESTORE: begin
        if (abort) begin
          idx_next = FIRST_IDX;
        end else if (restore_fire) begin
          if (at_last) begin
            done_next = 1'b1;
            idx_next  = FIRST_IDX;
          end else begin
            idx_next = idx + 5'd1;
          end
        end
      end
      default: begin
        out_valid_next = 1'b0;
        idx_next       = FIRST_IDX;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= FIRST_IDX;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      idx       <= idx_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      done      <= done_next;
    end
  end

  // Output decode; the write port is purely combinational so the register
  // file commits on the same edge that completes the input beat.
  always_comb begin
    busy          = (state != ST_IDLE);
    in_ready      = (state == ST_RESTORE);
    rf_read_addr  = idx;
    rf_write_en   = restore_fire && !abort;
    rf_write_addr = idx;
    rf_write_data = in_data;
    dbg_state     = state;
  end

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Testbench for regfile_ctx_engine: a behavioural register file, a scenario
// table, a randomized phase, and hand-written latency/reset/parameter
// sequences. Expected words come from an independent model of the register
// contents.
module tb_regfile_ctx_engine;

  localparam int FIRST  = 1;
  localparam int LAST   = 31;
  localparam int N      = LAST - FIRST + 1;
  localparam int BUDGET = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals (default parameters) ----------------
  logic        start, mode, abort;
  logic        busy, done;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_write_en;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [1:0]  dbg_state;

  // ---------------- second DUT: FIRST_REG=8, LAST_REG=15 ----------------
  logic        p2_start, p2_busy, p2_done;
  logic [4:0]  p2_read_addr, p2_write_addr;
  logic [31:0] p2_read_data, p2_write_data, p2_out_data;
  logic        p2_write_en, p2_out_valid, p2_ready, p2_in_ready;
  logic [1:0]  p2_state;

  // ---------------- register file environment ----------------
  logic [31:0] rf[32];
  logic [31:0] preload_img[32];
  logic        preload_req;
  logic [31:0] model_rf[32];

  assign rf_read_data = (rf_read_addr == 5'd0) ? 32'd0 : rf[rf_read_addr];
  assign p2_read_data = (p2_read_addr == 5'd0) ? 32'd0 : rf[p2_read_addr];

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 32; i++) rf[i] <= preload_img[i];
    end else if (rf_write_en && rf_write_addr != 5'd0) begin
      rf[rf_write_addr] <= rf_write_data;
    end
  end

  regfile_ctx_engine #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .done(done),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_en(rf_write_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dbg_state(dbg_state)
  );

  regfile_ctx_engine #(.FIRST_REG(8), .LAST_REG(15)) dut_p2 (
    .clk(clk), .reset(reset), .start(p2_start), .mode(1'b0), .abort(1'b0),
    .busy(p2_busy), .done(p2_done),
    .rf_read_addr(p2_read_addr), .rf_read_data(p2_read_data),
    .rf_write_addr(p2_write_addr), .rf_write_data(p2_write_data),
    .rf_write_en(p2_write_en),
    .out_data(p2_out_data), .out_valid(p2_out_valid), .out_ready(p2_ready),
    .in_data(32'd0), .in_valid(1'b0), .in_ready(p2_in_ready),
    .dbg_state(p2_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic rand_vals);
    for (int i = 0; i < 32; i++) begin
      preload_img[i] = (i == 0) ? 32'd0 : (rand_vals ? $urandom : 32'hA5A5_0000 + 32'(i));
      model_rf[i]    = preload_img[i];
    end
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), rf[i], model_rf[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(rf_write_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rf_read_addr), 32'(FIRST));
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // pattern 0: always 1; 1: 1,0,0,1 repeating; 2: random; 3: gap every third cycle
  function automatic logic pat_bit(input int pat, input int cyc);
    case (pat)
      0: return 1'b1;
      1: return (cyc % 4 == 0) || (cyc % 4 == 3);
      2: return 1'($urandom_range(0, 1));
      default: return (cyc % 3 != 2);
    endcase
  endfunction

  // Runs one operation from start to done/abort, checking every beat against
  // the model. Called and returns at posedge+1.
  task automatic run_op(input logic op, input int pat, input int abort_after,
                        input int start_at, input logic seq_data,
                        output int words, output int dones);
    int cyc;
    logic finished, aborting, held, drv;
    logic [31:0] held_data, exp_w;
    logic [4:0] widx;
    words = 0; dones = 0; cyc = 0; finished = 1'b0; held = 1'b0; held_data = '0;
    exp_q.delete();
    if (op == 1'b0) for (int r = FIRST; r <= LAST; r++) exp_q.push_back(model_rf[r]);
    start = 1'b1; mode = op;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!finished) begin
      aborting = (abort_after >= 0) && (words == abort_after);
      drv      = pat_bit(pat, cyc);
      abort    = aborting;
      if (cyc == start_at) begin start = 1'b1; mode = ~op; end
      else begin start = 1'b0; mode = 1'b0; end
      if (op == 1'b0) begin
        out_ready = aborting ? 1'b0 : drv;
      end else begin
        in_valid = drv;
        in_data  = seq_data ? 32'h1000 + 32'(FIRST + words) : $urandom;
      end
      #1;
      if (op == 1'b0) begin
        if (held) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", out_data, held_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 32'(out_valid), 32'd0);
          end else begin
            exp_w = exp_q.pop_front();
            check($sformatf("save_word%0d", words + 1), out_data, exp_w);
          end
          words++;
        end
        held      = out_valid && !out_ready;
        held_data = out_data;
      end else begin
        check("in_ready", 32'(in_ready), 32'd1);
        if (in_valid && !aborting) begin
          widx = 5'(FIRST + words);
          check("wr_en", 32'(rf_write_en), 32'd1);
          check("wr_addr", 32'(rf_write_addr), 32'(widx));
          check("wr_data", rf_write_data, in_data);
          if (widx != 5'd0) model_rf[widx] = in_data;
          words++;
        end else begin
          check("wr_en_idle", 32'(rf_write_en), 32'd0);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (done) dones++;
      if (aborting) begin
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        finished = 1'b1;
      end else if (words == N) begin
        check("final_done", 32'(done), 32'd1);
        check("final_busy", 32'(busy), 32'd0);
        finished = 1'b1;
      end else begin
        check("no_early_done", 32'(done), 32'd0);
        if (cyc >= BUDGET) begin
          check("op_timeout", 32'(cyc), 32'd0);
          finished = 1'b1;
        end
      end
    end
    abort = 1'b0; start = 1'b0; mode = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    if (done) dones++;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic op;
    int   pat;
    int   abort_after;
    int   start_at;
    logic seq_data;
    int   exp_words;
    logic exp_done;
  } scen_t;

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- main test ----------------
  initial begin
    scen_t scen[9];
    int words, dones, p2_words, ab, sa;
    logic op;

    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0; preload_req = 1'b0;
    p2_start = 1'b0; p2_ready = 1'b0;
    #1;
    check_reset_vals("reset");
    preload(1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("post_reset");

    // SAVE latency with out_ready held high: word k valid after Ek.
    out_ready = 1'b1;
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("lat_busy_e0", 32'(busy), 32'd1);
    check("lat_rd_addr_e0", 32'(rf_read_addr), 32'(FIRST));
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      check($sformatf("lat_valid_e%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("lat_data_e%0d", k), out_data, 32'hA5A5_0000 + 32'(k));
      check($sformatf("lat_done_e%0d", k), 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    check("lat_done_end", 32'(done), 32'd1);
    check("lat_busy_end", 32'(busy), 32'd0);
    check("lat_valid_end", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("lat_done_drop", 32'(done), 32'd0);

    // Scenario table: {op, pattern, abort_after, start_at, seq_data, words, done}
    scen[0] = '{1'b0, 0, -1, -1, 1'b0, N,  1'b1};
    scen[1] = '{1'b0, 1, -1, -1, 1'b0, N,  1'b1};
    scen[2] = '{1'b0, 0, 10, -1, 1'b0, 10, 1'b0};
    scen[3] = '{1'b0, 1, -1,  7, 1'b0, N,  1'b1};
    scen[4] = '{1'b1, 3, -1, -1, 1'b1, N,  1'b1};
    scen[5] = '{1'b1, 0,  5, -1, 1'b1, 5,  1'b0};
    scen[6] = '{1'b1, 0, 30, -1, 1'b1, 30, 1'b0};
    scen[7] = '{1'b0, 0, 30, -1, 1'b0, 30, 1'b0};
    scen[8] = '{1'b1, 3, -1,  4, 1'b0, N,  1'b1};
    for (int s = 0; s < 9; s++) begin
      preload(1'b0);
      run_op(scen[s].op, scen[s].pat, scen[s].abort_after, scen[s].start_at,
             scen[s].seq_data, words, dones);
      check($sformatf("scen%0d_words", s), 32'(words), 32'(scen[s].exp_words));
      check($sformatf("scen%0d_dones", s), 32'(dones), 32'(scen[s].exp_done));
      check_rf($sformatf("scen%0d", s));
    end

    // Randomized operations against the model.
    for (int t = 0; t < 8; t++) begin
      preload(1'b1);
      op = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N - 1)) : -1;
      sa = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_op(op, 2, ab, sa, 1'b0, words, dones);
      check($sformatf("rand%0d_words", t), 32'(words), 32'((ab >= 0) ? ab : N));
      check($sformatf("rand%0d_dones", t), 32'(dones), 32'((ab >= 0) ? 0 : 1));
      check_rf($sformatf("rand%0d", t));
    end

    // Reset pulse in the middle of RESTORE after 5 writes.
    preload(1'b0);
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h2000 + 32'(FIRST + i);
      model_rf[FIRST + i] = in_data;
      @(posedge clk); #1;
    end
    in_data = 32'hDEAD_BEEF;
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_reset_vals("after_mid_reset");
    check_rf("mid_reset");

    // Parameter override instance: exactly r8..r15, addresses within range.
    preload(1'b1);
    p2_start = 1'b1;
    @(posedge clk); #1;
    p2_start = 1'b0;
    p2_ready = 1'b1;
    p2_words = 0;
    for (int c = 0; c < 100 && p2_words < 8; c++) begin
      check("p2_addr_range", 32'((p2_read_addr >= 5'd8) && (p2_read_addr <= 5'd15)), 32'd1);
      if (p2_out_valid) begin
        check($sformatf("p2_word%0d", p2_words), p2_out_data, model_rf[8 + p2_words]);
        p2_words++;
      end
      @(posedge clk); #1;
      check("p2_done", 32'(p2_done), 32'(p2_words == 8));
    end
    check("p2_word_count", 32'(p2_words), 32'd8);
    check("p2_busy_end", 32'(p2_busy), 32'd0);
    @(posedge clk); #1;
    check("p2_no_extra", 32'(p2_out_valid), 32'd0);
    check("p2_done_drop", 32'(p2_done), 32'd0);
    p2_ready = 1'b0;

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_ctx_engine.md
# regfile_ctx_engine

Context save/restore engine for the 32×32 MIPS register file. In SAVE mode it walks registers FIRST_REG..LAST_REG through a register-file read port and streams their contents out over a valid/ready interface. In RESTORE mode it accepts a valid/ready word stream and writes the words to the same register range through the register-file write port. It sits between the register file and a trap/context-switch controller or debug port; it is the initiator side of the register file's read and write ports.

## Interface
- FIRST_REG, 1: first register index transferred, 0..31; register 0 is excluded by default.
- LAST_REG, 31: last register index transferred; must be ≥ FIRST_REG.
- clk  in  1  clock; positive-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- mode  in  1  sampled with start; 0 = SAVE, 1 = RESTORE.
- abort  in  1  synchronous cancel of the current operation.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse on successful completion.
- rf_read_addr  out  5  drives the register-file read address.
- rf_read_data  in  32  asynchronous read data from the register file.
- rf_write_addr  out  5  drives the register-file write address.
- rf_write_data  out  32  drives the register-file write data.
- rf_write_en  out  1  drives the register-file write enable.
- out_data  out  32  saved word stream.
- out_valid  out  1  saved word stream valid.
- out_ready  in  1  saved word stream ready.
- in_data  in  32  restore word stream.
- in_valid  in  1  restore word stream valid.
- in_ready  out  1  restore word stream ready.

## Operation
- **States:** IDLE, SAVE, SAVE_DRAIN, RESTORE.
- **Index:** 5-bit `idx`. It loads FIRST_REG on start and increments by 1 per transfer. It never wraps, because LAST_REG ≤ 31 and the range is checked before incrementing.
- **IDLE:**
  - start=1, mode=0 → SAVE.
  - start=1, mode=1 → RESTORE.
- **SAVE:**
  - rf_read_addr = idx, combinational from the idx register.
  - Output register loads when out_valid=0 or (out_valid & out_ready): out_data ← rf_read_data, out_valid ← 1, idx ← idx+1.
  - On the load of LAST_REG → SAVE_DRAIN.
- **SAVE_DRAIN:**
  - Hold out_data/out_valid until out_ready.
  - On the handshake: out_valid ← 0, done ← 1, → IDLE.
- **RESTORE:**
  - in_ready = 1.
  - When in_valid & in_ready: rf_write_en = 1, rf_write_addr = idx, rf_write_data = in_data, all combinational, so the register file commits on the same edge. Then idx ← idx+1.
  - On the write of LAST_REG: done ← 1, → IDLE.
- **Outside RESTORE:** in_ready = 0 and rf_write_en = 0. rf_write_addr and rf_write_data are don't-care while rf_write_en = 0.
- **out_data / out_valid:** out_data holds its value whenever out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on abort or reset.
- **Simultaneous events:**
  - start while busy: ignored.
  - abort in IDLE: no effect.
  - abort together with a final transfer: abort wins; no done, already-committed writes stand.
- **Abort (any non-IDLE state):** next edge → IDLE, out_valid ← 0, done stays 0, no rf write on that edge.
- **Word count:** LAST_REG−FIRST_REG+1 (31 by default).

## Timing
- **Reset values:** state=IDLE, idx=FIRST_REG, out_valid=0, out_data=0, done=0, busy=0, in_ready=0, rf_write_en=0, rf_read_addr=FIRST_REG.
- **Reset mid-operation:** returns to reset values immediately; no partial word is emitted after deassertion.
- **Start edge:** call it E0. busy=1 from E0.
- **SAVE latency:**
  - Word k (k=1..N) is valid after edge Ek when out_ready is held high.
  - Throughput is 1 word/cycle.
  - done is high for the cycle after the final handshake edge; busy falls on that same edge.
- **RESTORE latency:**
  - in_ready=1 from E0.
  - With in_valid held high, writes land at E1..EN.
  - done is high for the cycle after EN.
- **done:** exactly one cycle wide.

## Test plan
- **SAVE, default params, out_ready=1:** registers preloaded rN=0xA5A50000+N; start/mode=0 at E0 → 31 words 0xA5A50001..0xA5A5001F on E1..E31; done=1 only after E32; busy=0 after E32.
- **SAVE with out_ready toggling 1,0,0,1 repeating:** same 31 words, in order, none duplicated or dropped; out_data stable while out_valid=1 and out_ready=0.
- **RESTORE:** in_data=0x1000+k for k=1..31 with in_valid gaps every third cycle → register k reads 0x1000+k afterwards; r0 still reads 0; rf_write_en never asserted during a gap; done once after the 31st write.
- **Abort:** abort during SAVE after word 10 → out_valid=0 next cycle, no done, busy=0. Abort during RESTORE after 5 writes → r1..r5 updated, r6..r31 unchanged.
- **Start while busy:** start during SAVE is ignored (word sequence unaffected). Reset pulse mid-RESTORE → all outputs at reset values, registers already written stay written.
- **Parameter override FIRST_REG=8, LAST_REG=15:** SAVE emits exactly 8 words (r8..r15); done after the 8th handshake; rf_read_addr stays within 8..15.
